// File: rtl/fuzzy_pkg.sv
// rtl/fuzzy_pkg.sv - shared Q1.15 types, widths, state enum and saturation helper
// Contents:
//   q15_t        16-bit Q1.15 value
//   Q15_MAX      largest positive Q1.15 value
//   ACC_W        accumulator width (holds N_RULES * 32767 without overflow)
//   agg_state_e  frame aggregator states
//   sat_q15()    clamp an accumulator value to the Q1.15 range
package fuzzy_pkg;

  typedef logic [15:0] q15_t;

  localparam q15_t Q15_MAX = 16'd32767;
  localparam int   ACC_W   = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } agg_state_e;

  // Accumulators are never negative, so only the upper bound needs clamping.
  function automatic q15_t sat_q15(input logic [ACC_W-1:0] a);
    if (a > ACC_W'(Q15_MAX)) begin
      return Q15_MAX;
    end
    return q15_t'(a);
  endfunction

endpackage

// File: rtl/q15_mul.sv
// rtl/q15_mul.sv - sanitise two Q1.15 inputs and form their Q1.15 product term
// Ports:
//   w_in  input  Q1.15 firing strength (negative treated as 0)
//   g_in  input  Q1.15 singleton (negative treated as 0)
//   w_s   output sanitised firing strength
//   term  output (w*g)>>15, truncated; half-up rounded when AGG_ROUND_EN is defined
// Configuration macro: AGG_ROUND_EN
module q15_mul
  import fuzzy_pkg::*;
(
  input  logic [15:0] w_in,
  input  logic [15:0] g_in,
  output q15_t        w_s,
  output q15_t        term
);

  q15_t        g_s;
  logic [31:0] prod;

  assign w_s  = w_in[15] ? 16'd0 : w_in;
  assign g_s  = g_in[15] ? 16'd0 : g_in;
  assign prod = {16'd0, w_s} * {16'd0, g_s};

  // Both operands are at most 32767, so the shifted result never exceeds
  // 32766 even after rounding and always fits in 16 bits.
`ifdef AGG_ROUND_EN
  assign term = 16'((prod + 32'd16384) >> 15);
`else
  assign term = 16'(prod >> 15);
`endif

endmodule

// File: rtl/agg_sums.sv
// rtl/agg_sums.sv - per-frame sums of rule weights and weight*singleton for the defuzzifier
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   in_valid/in_ready     rule beat handshake; in_last marks the final beat
//   w_in, g_in            Q1.15 firing strength and singleton
//   S_w, S_wg             saturated Q1.15 sums of the last closed frame
//   out_valid/out_ready   frame result handshake
//   len_err               frame closed on N_RULES count rather than in_last
// Configuration macro: AGG_ROUND_EN (rounding inside q15_mul)
module agg_sums
  import fuzzy_pkg::*;
#(
  parameter int N_RULES = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [15:0] w_in,
  input  logic [15:0] g_in,
  output logic [15:0] S_w,
  output logic [15:0] S_wg,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        len_err
);

  localparam int CNT_W = $clog2(N_RULES + 1);

  agg_state_e       state, state_nxt;
  logic [ACC_W-1:0] acc_w, acc_wg;
  logic [ACC_W-1:0] sum_w, sum_wg;
  logic [CNT_W-1:0] count, count_nxt;
  logic             accept, close;
  q15_t             w_s, term;

  q15_mul u_mul (
    .w_in (w_in),
    .g_in (g_in),
    .w_s  (w_s),
    .term (term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    close     = 1'b0;
    sum_w     = acc_w + ACC_W'(w_s);
    sum_wg    = acc_wg + ACC_W'(term);
    count_nxt = count + CNT_W'(1);

    case (state)
      ST_IDLE: begin
        in_ready = ~rst;
        // First beat starts the frame fresh: nothing from the prior frame.
        sum_w     = ACC_W'(w_s);
        sum_wg    = ACC_W'(term);
        count_nxt = CNT_W'(1);
      end
      ST_ACCUM: begin
        in_ready = ~rst;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    accept = in_valid && in_ready;
    close  = accept && (in_last || (count_nxt == CNT_W'(N_RULES)));
    if (accept) begin
      state_nxt = close ? ST_DONE : ST_ACCUM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_w   <= '0;
      acc_wg  <= '0;
      count   <= '0;
      S_w     <= '0;
      S_wg    <= '0;
      len_err <= 1'b0;
    end else begin
      if (accept) begin
        acc_w  <= sum_w;
        acc_wg <= sum_wg;
        count  <= count_nxt;
      end
      // Results are taken from the running sums including this beat so the
      // frame appears one cycle after its last beat.
      if (close) begin
        S_w     <= sat_q15(sum_w);
        S_wg    <= sat_q15(sum_wg);
        len_err <= ~in_last;
      end
    end
  end

endmodule

// File: doc/agg_sums.md
AGG_SUMS -- requirements
Module: agg_sums

Interface
REQ-001 SHALL have parameter N_RULES, default 9, giving the maximum rule beats per frame (3x3 rule base).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  a rule beat is present.
REQ-005 SHALL have port in_ready  output  1  the block accepts a beat this cycle.
REQ-006 SHALL have port in_last  input  1  marks the final beat of a frame.
REQ-007 SHALL have port w_in  input  16  rule firing strength, Q1.15.
REQ-008 SHALL have port g_in  input  16  rule output singleton, Q1.15.
REQ-009 SHALL have port S_w  output  16  sum of weights, Q1.15, saturated; feeds the defuzzifier.
REQ-010 SHALL have port S_wg  output  16  sum of weight*singleton, Q1.15, saturated; feeds the defuzzifier.
REQ-011 SHALL have port out_valid  output  1  S_w and S_wg hold a completed frame.
REQ-012 SHALL have port out_ready  input  1  the consumer takes the frame.
REQ-013 SHALL have port len_err  output  1  the last frame closed on count, not on in_last; valid with out_valid.

Function
REQ-014 SHALL implement FSM IDLE, ACCUM, DONE; a beat is accepted when in_valid&&in_ready.
REQ-015 SHALL drive in_ready=1 in IDLE and ACCUM, and 0 in DONE and during reset.
REQ-016 SHALL sanitise inputs: w_in or g_in with bit15 set (negative) is treated as 0.
REQ-017 SHALL compute term = (w*g)>>15 as a 32-bit product, truncated; term is at most 32766.
REQ-018 SHALL load, on the first accepted beat in IDLE, acc_w=w, acc_wg=term and count=1, then go to ACCUM, with no carry-over from the prior frame.
REQ-019 SHALL, in ACCUM, add each accepted beat into 20-bit accumulators and increment count.
REQ-020 SHALL close the frame on an accepted beat with in_last=1, or when count reaches N_RULES; a single beat with in_last=1 in IDLE closes immediately.
REQ-021 SHALL set len_err=1 when the frame closes on count without in_last, else 0.
REQ-022 SHALL, on frame close, register S_w=min(acc_w,32767) and S_wg=min(acc_wg,32767), enter DONE and assert out_valid the next cycle (1-cycle latency after the last beat).
REQ-023 SHALL hold S_w, S_wg, len_err and out_valid stable in DONE until out_ready=1, then return to IDLE.
REQ-024 SHALL keep S_w and S_wg at their last frame values after the handshake, until the next frame closes.
REQ-025 SHALL ignore in_valid while in DONE; no beat is accepted or lost.

Reset
REQ-026 SHALL, on rst=1, immediately clear S_w, S_wg, out_valid, len_err, the accumulators and count, and enter IDLE, including mid-frame.
REQ-027 SHALL discard a partial frame on reset and emit no output for it.

Configuration
REQ-028 SHALL, when AGG_ROUND_EN is defined, round the product half-up: term=(w*g+16384)>>15.
REQ-029 SHALL, without AGG_ROUND_EN, truncate the product per REQ-017.

Structure
REQ-030 SHALL take q15_t, Q15_MAX=16'd32767, the ACC_W=20 width and the state enum from the shared package fuzzy_pkg.
REQ-031 SHALL place the sanitise, multiply and truncate/round logic in sub-module q15_mul.

Verification
REQ-032 Reset: assert rst mid-frame after 2 beats -> S_w=0, S_wg=0, out_valid=0, in_ready=0; after release, a new 1-beat frame is unaffected by the discarded beats.
REQ-033 Single beat w=16384, g=32767, last=1 -> next cycle out_valid=1, S_w=16384, S_wg=16383 (16384 with AGG_ROUND_EN), len_err=0.
REQ-034 Saturation: 4 beats w=8192, g=16384, last on 4th -> S_w=32767 (clamped from 32768), S_wg=16384; 3-beat variant -> S_w=24576, S_wg=12288.
REQ-035 Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 -> in_ready=0, outputs stable, no beats accepted; out_ready=1 -> IDLE.
REQ-036 Overrun: 9 beats w=1000, g=32767, in_last never set -> frame closes on the 9th beat, S_w=9000, S_wg=8991 (9000 with AGG_ROUND_EN), len_err=1.
REQ-037 Negative input: beat w=16'h8000, g=16384, last=1 -> S_w=0, S_wg=0.
